// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the accumulator CPU control unit
package ctrl_pkg;

  // Opcode field of the 9-bit instruction
  typedef enum logic [2:0] {
    OP_ALU0  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_ALU1  = 3'b011,
    OP_LOAD  = 3'b100,
    OP_MOV   = 3'b101,
    OP_BR    = 3'b110,
    OP_STORE = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int INST_W = 9;

  // Halt is the all-ones instruction word
  localparam logic [INST_W-1:0] HALT = '1;

  // Width of the memory wait counter, never below one bit
  function automatic int wait_cnt_w(input int lat);
    return (lat <= 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - opcode to raw datapath enables, gated later by the FSM
module op_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] op_i,
  output logic       reg_wr_o,
  output logic       mov_o,
  output logic       shift_o,
  output logic       load_o,
  output logic       mem_wr_o,
  output logic       boe_o,
  output logic       is_mem_o
);

  // Pure table lookup; halt detection and sequencing are handled by ctrl_fsm
  always_comb begin
    reg_wr_o = 1'b0;
    mov_o    = 1'b0;
    shift_o  = 1'b0;
    load_o   = 1'b0;
    mem_wr_o = 1'b0;
    boe_o    = 1'b0;
    is_mem_o = 1'b0;
    case (op_t'(op_i))
      OP_ALU0, OP_ALU1: reg_wr_o = 1'b1;
      OP_SHL, OP_SHR: begin
        reg_wr_o = 1'b1;
        shift_o  = 1'b1;
      end
      OP_LOAD: begin
        reg_wr_o = 1'b1;
        load_o   = 1'b1;
        is_mem_o = 1'b1;
      end
      OP_MOV: begin
        reg_wr_o = 1'b1;
        mov_o    = 1'b1;
      end
      OP_BR:    boe_o = 1'b1;
      OP_STORE: begin
        mem_wr_o = 1'b1;
        is_mem_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - sequencing control unit: decode, memory stall, done flag, retire count
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int MEM_LAT = 1,
  parameter int CW      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  output logic          RegWrEn,
  output logic          MovEn,
  output logic          Shift,
  output logic          LoadInst,
  output logic          MemWrEn,
  output logic          BOE,
  output logic          PcEn,
  output logic          Stall,
  output logic          Ack,
  output logic [CW-1:0] InstCount
);

  localparam int CNTW = wait_cnt_w(MEM_LAT);
  localparam bit USE_WAIT = (MEM_LAT > 0);
  localparam logic [CNTW-1:0] WAIT_INIT = (MEM_LAT > 0) ? CNTW'(MEM_LAT - 1) : '0;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   count_q, count_d;

  logic [OPW-1:0] op_live;
  logic [OPW-1:0] op_sel;
  logic           is_halt;

  logic dec_reg_wr, dec_mov, dec_shift, dec_load, dec_mem_wr, dec_boe, dec_is_mem;

  logic reg_wr, mov_en, shift_en, load_en, mem_wr, boe_en, pc_en, stall, ack;

  assign op_live = Instruction[IW-1 -: OPW];
  assign is_halt = &Instruction;

  // While waiting on memory the opcode captured at entry is decoded, not the live word
  assign op_sel = (state_q == MEM_WAIT) ? op_q : op_live;

  op_decode u_op_decode (
    .op_i     (op_sel),
    .reg_wr_o (dec_reg_wr),
    .mov_o    (dec_mov),
    .shift_o  (dec_shift),
    .load_o   (dec_load),
    .mem_wr_o (dec_mem_wr),
    .boe_o    (dec_boe),
    .is_mem_o (dec_is_mem)
  );

  // State, captured opcode, wait counter and retire counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; Start is only honoured from IDLE or DONE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = EXEC;
          count_d = '0;
        end
      end
      EXEC: begin
        if (is_halt) begin
          state_d = DONE;
        end else if (dec_is_mem && USE_WAIT) begin
          state_d = MEM_WAIT;
          op_d    = op_live;
          cnt_d   = WAIT_INIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pc_en) begin
      count_d = count_q + CW'(1);
    end
  end

  // Output decode: enables gated by state, write enables only on the retiring cycle
  always_comb begin
    reg_wr   = 1'b0;
    mov_en   = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    mem_wr   = 1'b0;
    boe_en   = 1'b0;
    pc_en    = 1'b0;
    stall    = 1'b0;
    ack      = 1'b0;
    case (state_q)
      EXEC: begin
        if (!is_halt) begin
          if (dec_is_mem && USE_WAIT) begin
            stall   = 1'b1;
            load_en = dec_load;
          end else begin
            reg_wr   = dec_reg_wr;
            mov_en   = dec_mov;
            shift_en = dec_shift;
            load_en  = dec_load;
            mem_wr   = dec_mem_wr;
            boe_en   = dec_boe;
            pc_en    = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        load_en = dec_load;
        if (cnt_q != '0) begin
          stall = 1'b1;
        end else begin
          pc_en  = 1'b1;
          reg_wr = dec_reg_wr;
          mem_wr = dec_mem_wr;
        end
      end
      DONE:    ack = 1'b1;
      default: ;
    endcase
  end

  assign RegWrEn   = reg_wr;
  assign MovEn     = mov_en;
  assign Shift     = shift_en;
  assign LoadInst  = load_en;
  assign MemWrEn   = mem_wr;
  assign BOE       = boe_en;
  assign PcEn      = pc_en;
  assign Stall     = stall;
  assign Ack       = ack;
  assign InstCount = count_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - scoreboard bench for ctrl_fsm across three latency/width variants
module tb_ctrl_fsm;
  import ctrl_pkg::*;

  typedef struct {
    logic [8:0]  f;
    logic [15:0] c;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] Instruction = '0;

  always #5 Clk = ~Clk;

  // Flag bit order: RegWrEn MovEn Shift LoadInst MemWrEn BOE PcEn Stall Ack
  wire [8:0]  fl0, fl1, fl2;
  wire [3:0]  ic0;
  wire [15:0] ic1, ic2;

  ctrl_fsm #(.IW(9), .OPW(3), .MEM_LAT(2), .CW(4)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .RegWrEn(fl0[8]), .MovEn(fl0[7]), .Shift(fl0[6]), .LoadInst(fl0[5]), .MemWrEn(fl0[4]),
    .BOE(fl0[3]), .PcEn(fl0[2]), .Stall(fl0[1]), .Ack(fl0[0]), .InstCount(ic0)
  );

  ctrl_fsm #(.IW(9), .OPW(3), .MEM_LAT(0), .CW(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .RegWrEn(fl1[8]), .MovEn(fl1[7]), .Shift(fl1[6]), .LoadInst(fl1[5]), .MemWrEn(fl1[4]),
    .BOE(fl1[3]), .PcEn(fl1[2]), .Stall(fl1[1]), .Ack(fl1[0]), .InstCount(ic1)
  );

  ctrl_fsm #(.IW(9), .OPW(3), .MEM_LAT(3), .CW(16)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .RegWrEn(fl2[8]), .MovEn(fl2[7]), .Shift(fl2[6]), .LoadInst(fl2[5]), .MemWrEn(fl2[4]),
    .BOE(fl2[3]), .PcEn(fl2[2]), .Stall(fl2[1]), .Ack(fl2[0]), .InstCount(ic2)
  );

  // Reference model: program mode 0 idle / 1 running / 2 memory wait / 3 done
  int          lat [3] = '{2, 0, 3};
  int          cwd [3] = '{4, 16, 16};
  int          mode [3];
  int          left [3];
  int          mop [3];
  int unsigned retired [3];

  exp_t q0[$], q1[$], q2[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [8:0] enables_of(input int op);
    logic [8:0] f;
    f = '0;
    case (op)
      0, 3: f[8] = 1'b1;
      1, 2: begin f[8] = 1'b1; f[6] = 1'b1; end
      4:    begin f[8] = 1'b1; f[5] = 1'b1; end
      5:    begin f[8] = 1'b1; f[7] = 1'b1; end
      6:    f[3] = 1'b1;
      7:    f[4] = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  task automatic model_step(input int i, input logic [8:0] ins, input logic st, input logic rs);
    exp_t e;
    int   op;
    e.f = '0;
    e.c = rs ? 16'd0 : 16'(retired[i]);
    if (rs) begin
      mode[i] = 0;
      retired[i] = 0;
    end else begin
      case (mode[i])
        0: if (st) begin mode[i] = 1; retired[i] = 0; end
        3: begin
          e.f[0] = 1'b1;
          if (st) begin mode[i] = 1; retired[i] = 0; end
        end
        1: begin
          if (ins == HALT) begin
            mode[i] = 3;
          end else begin
            op = int'(ins[8:6]);
            if ((op == 4 || op == 7) && lat[i] > 0) begin
              e.f[1] = 1'b1;
              e.f[5] = (op == 4);
              mop[i] = op;
              left[i] = lat[i];
              mode[i] = 2;
            end else begin
              e.f = enables_of(op);
              e.f[2] = 1'b1;
              retired[i] = (retired[i] + 1) % (32'd1 << cwd[i]);
            end
          end
        end
        default: begin
          left[i] = left[i] - 1;
          e.f[5] = (mop[i] == 4);
          if (left[i] == 0) begin
            e.f[2] = 1'b1;
            e.f[8] = (mop[i] == 4);
            e.f[4] = (mop[i] == 7);
            mode[i] = 1;
            retired[i] = (retired[i] + 1) % (32'd1 << cwd[i]);
          end else begin
            e.f[1] = 1'b1;
          end
        end
      endcase
    end
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic cyc(input logic [8:0] ins, input logic st, input logic rs);
    @(posedge Clk);
    #1;
    Instruction = ins;
    Start = st;
    Reset = rs;
    for (int i = 0; i < 3; i++) model_step(i, ins, st, rs);
  endtask

  task automatic chk(input int i, input logic [8:0] f, input logic [15:0] c);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      n_cmp++;
      if (f !== e.f) begin
        n_bad++;
        $display("FAIL dut%0d_flags at %0t: got %b want %b", i, $time, f, e.f);
      end
      n_cmp++;
      if (c !== e.c) begin
        n_bad++;
        $display("FAIL dut%0d_count at %0t: got %0d want %0d", i, $time, c, e.c);
      end
    end
  endtask

  // Monitor: every falling edge each DUT presents a full output set to compare
  always @(negedge Clk) begin
    chk(0, fl0, {12'd0, ic0});
    chk(1, fl1, ic1);
    chk(2, fl2, ic2);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0; left[i] = 0; mop[i] = 0; retired[i] = 0;
    end
    cyc(9'h000, 1'b0, 1'b1);
    cyc(9'h000, 1'b0, 1'b0);
    cyc(9'b000_000001, 1'b1, 1'b0);
    cyc(9'b000_000001, 1'b0, 1'b0);
    cyc(9'b100_000011, 1'b0, 1'b0);
    cyc(9'b010_101010, 1'b1, 1'b0);
    cyc(9'b011_010101, 1'b0, 1'b0);
    cyc(9'b111_000010, 1'b0, 1'b0);
    cyc(9'b001_111000, 1'b0, 1'b0);
    cyc(9'b110_000111, 1'b0, 1'b0);
    cyc(9'b000_000000, 1'b0, 1'b0);
    cyc(9'b000_000000, 1'b0, 1'b0);
    cyc(9'b110_000001, 1'b0, 1'b0);
    cyc(9'b001_000001, 1'b0, 1'b0);
    cyc(9'b101_000001, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) cyc(9'(k), 1'b0, 1'b0);
    cyc(HALT, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(9'b000_000001, 1'b0, 1'b0);
    cyc(9'b000_000001, 1'b1, 1'b0);
    cyc(9'b000_000011, 1'b0, 1'b0);
    cyc(9'b111_000010, 1'b0, 1'b0);
    cyc(9'b111_000010, 1'b0, 1'b1);
    cyc(9'b111_000010, 1'b0, 1'b0);
    cyc(9'b000_000001, 1'b1, 1'b0);
    cyc(9'b000_000001, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [8:0] ins;
      ins = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom);
      cyc(ins, ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0));
    end
    cyc(9'h000, 1'b0, 1'b0);
    @(negedge Clk);
    #1;
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q0.size() + q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Sequencing control unit for the 9-bit accumulator CPU, replacing the purely combinational opcode decoder. It decodes the opcode field of the current instruction into datapath enables. It stalls the PC for a parametrised number of cycles on loads and stores and latches a sticky program-done flag. It also counts retired instructions. It sits between instruction memory and the PC, register file and data memory.

## Interface
- IW, 9: instruction width.
- OPW, 3: opcode field width; the field is Instruction[IW-1 -: OPW].
- MEM_LAT, 1: extra wait cycles for load/store (0 = single-cycle).
- CW, 16: retired-instruction counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; returns the FSM to IDLE.
- Start  in  1  one-cycle pulse; begins a program from IDLE or DONE.
- Instruction  in  IW  current machine code from instruction memory.
- RegWrEn  out  1  register-file write.
- MovEn  out  1  move instruction.
- Shift  out  1  shift instruction.
- LoadInst  out  1  route data memory to the register file.
- MemWrEn  out  1  data-memory write.
- BOE  out  1  branch on equal; the PC unit selects the branch target.
- PcEn  out  1  advance the PC / instruction retires this cycle.
- Stall  out  1  PC held for a multi-cycle memory instruction.
- Ack  out  1  program done; sticky until Start or Reset.
- InstCount  out  CW  retired instructions since the last Start.

## Operation
Opcodes (OPW=3): 000/011 ALU, 001/010 shift, 100 load, 101 mov, 110 branch, 111 store. Halt is an all-ones Instruction.

FSM states:
- IDLE: all enables 0. Start → EXEC.
- EXEC:
  - Halt → DONE. All enables 0. Halt does not assert MemWrEn, even though its opcode is 111. This is a fix over the previous decoder.
  - ALU/shift/mov/branch: assert the decoded enables and PcEn for one cycle; stay in EXEC.
    - RegWrEn=1 for ALU, shift and mov.
    - Shift=1 for 001/010; MovEn=1 for 101; BOE=1 for 110.
  - Load/store with MEM_LAT=0: as above, completing in one cycle.
    - Load: LoadInst=1, RegWrEn=1.
    - Store: MemWrEn=1, RegWrEn=0.
  - Load/store with MEM_LAT>0: Stall=1, PcEn=0, LoadInst=1 for a load, no write enables. Load the wait counter with MEM_LAT-1 and go to MEM_WAIT.
- MEM_WAIT: Stall=1, LoadInst held for a load.
  - Counter≠0: decrement.
  - Counter=0: final cycle. Stall=0, PcEn=1. Load asserts RegWrEn; store asserts MemWrEn. → EXEC.
- DONE: Ack=1, all enables 0. Start → EXEC.

InstCount:
- Cleared on Start, when accepted in IDLE or DONE.
- Increments on every PcEn cycle.
- Wraps modulo 2^CW.

Boundary conditions:
- Start in EXEC or MEM_WAIT is ignored.
- Instruction changing during MEM_WAIT is ignored: the opcode is captured on entry.
- Reset mid-instruction aborts it with no write enable asserted.

## Timing
- Reset value of every output and state element is 0; the FSM is in IDLE and the counters are 0.
- Enables are combinational from the registered state, the captured opcode (in MEM_WAIT) or the live Instruction (in EXEC). No output depends combinationally on Start.
- Non-memory instruction: 1 cycle, PcEn in the same cycle it is presented.
- Load/store: MEM_LAT+1 cycles.
  - Stall is high for the first MEM_LAT cycles.
  - The write enable and PcEn are high in the last cycle only.
- Ack rises the cycle after the halt is presented. It falls the cycle after Start is accepted.
- A Start pulse makes EXEC active on the next edge. The first instruction is decoded in that cycle.

## Structure
- ctrl_pkg holds:
  - typedef enum op_t for the opcodes;
  - typedef enum state_t {IDLE, EXEC, MEM_WAIT, DONE};
  - localparam HALT = all ones.
- Sub-module op_decode: combinational op_t to raw enables. It is reused in EXEC and MEM_WAIT, then gated by the FSM.
- The wait counter is $clog2(MEM_LAT+1) bits wide, minimum 1.

## Test plan
- Reset asserted mid-run → all outputs 0 immediately; Start then instruction 9'b000_000001 → RegWrEn=1, PcEn=1, InstCount=1 next cycle.
- MEM_LAT=2, load 9'b100_000011 → Stall=1 for 2 cycles, LoadInst=1 for 3 cycles, RegWrEn=1 and PcEn=1 on the 3rd cycle only.
- MEM_LAT=2, store 9'b111_000010 → MemWrEn=1 exactly one cycle (the 3rd), RegWrEn=0 throughout.
- Instruction 9'h1FF → MemWrEn=0, Ack=1 next cycle and held for 10 idle cycles; Start → Ack=0, InstCount=0.
- MEM_LAT=0, branch then shift then mov → BOE, Shift, MovEn each high one cycle; InstCount=3.
- CW=4: 17 ALU instructions → InstCount wraps to 1. Reset asserted during MEM_WAIT → no MemWrEn/RegWrEn pulse, returns to IDLE.
